// File: rtl/demux1_2.sv
// One valid/ready input stream split into two outputs by a per-word select bit.
// Each output has its own first-word-fall-through FIFO and a delivered-word counter.
module demux1_2 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNTW-1:0]  out0_cnt,
  output logic [CNTW-1:0]  out1_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLCNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem   [2][DEPTH];
  logic [AW-1:0]    wptr  [2];
  logic [AW-1:0]    rptr  [2];
  logic [AW:0]      count [2];
  logic [CNTW-1:0]  cnt   [2];
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;

  // in_ready depends only on in_sel and registered occupancy, never on out*_ready
  always_comb begin
    full = '0;
    push = '0;
    pop  = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      full[c] = (count[c] == FULLCNT);
    end
    in_ready = !full[in_sel];
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
    pop[0] = out0_valid && out0_ready;
    pop[1] = out1_valid && out1_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < 2; c++) begin
        wptr[c]  <= '0;
        rptr[c]  <= '0;
        count[c] <= '0;
        cnt[c]   <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) begin
          mem[c][d] <= '0;
        end
      end
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wptr[c]] <= in_data;
          wptr[c]         <= wptr[c] + 1'b1;
        end
        if (pop[c]) begin
          rptr[c] <= rptr[c] + 1'b1;
          cnt[c]  <= cnt[c] + 1'b1;
        end
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + 1'b1;
          2'b01:   count[c] <= count[c] - 1'b1;
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  assign out0_valid = (count[0] != '0);
  assign out1_valid = (count[1] != '0);
  assign out0_data  = mem[0][rptr[0]];
  assign out1_data  = mem[1][rptr[1]];
  assign out0_cnt   = cnt[0];
  assign out1_cnt   = cnt[1];

endmodule
